hc_fifo_pf: RTL

//  Parametrised show-ahead synchronous FIFO. Successor to the fixed 512-bit block-buffer FIFO.

---
 rtl/hc_pkg.sv | 13 +
 rtl/hc_fifo_ram.sv | 23 ++
 rtl/hc_fifo_pf.sv | 109 ++++++++++
 3 files changed

// File: rtl/hc_pkg.sv
// Shared types and constants for the host-channel datapath.
package hc_pkg;

  typedef logic [511:0] t_block;

  localparam int unsigned HC_BLOCK_W = $bits(t_block);

  typedef struct packed {
    logic overflow;
    logic underflow;
  } t_fifo_err;

endpackage

// File: rtl/hc_fifo_ram.sv
// WIDTH x DEPTH storage: one registered write port, one asynchronous read port.
module hc_fifo_ram #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hc_fifo_pf.sv
// Parametrised show-ahead synchronous FIFO with occupancy/threshold status and flush.
// Optional sticky overflow/underflow flags and err_clr port when HC_FIFO_ERR_EN is defined.
module hc_fifo_pf
  import hc_pkg::*;
#(
  parameter int unsigned WIDTH     = HC_BLOCK_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 1,
  localparam int unsigned PW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             enq_en,
  output logic             not_full,
  output logic [WIDTH-1:0] deq_data,
  input  logic             deq_en,
  output logic             not_empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free,
  output logic             almost_full,
  output logic             almost_empty
`ifdef HC_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hc_fifo_pf: DEPTH must be a power of two and >= 2");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          enq_ok;
  logic          deq_ok;

  // Status is decoded purely from count_q so request inputs never reach outputs.
  assign count        = count_q;
  assign free         = CW'(DEPTH) - count_q;
  assign not_full     = (count_q != CW'(DEPTH));
  assign not_empty    = (count_q != '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  assign enq_ok = enq_en && not_full && !flush;
  assign deq_ok = deq_en && not_empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + 1'b1;
      if (deq_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_ok, deq_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  hc_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (enq_ok),
    .wr_addr (wr_ptr),
    .wr_data (enq_data),
    .rd_addr (rd_ptr),
    .rd_data (deq_data)
  );

`ifdef HC_FIFO_ERR_EN
  t_fifo_err err_q;
  logic      ovf_set;
  logic      udf_set;

  assign ovf_set = enq_en && !not_full && !flush;
  assign udf_set = deq_en && !not_empty && !flush;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q.overflow  <= (err_q.overflow  && !err_clr) || ovf_set;
      err_q.underflow <= (err_q.underflow && !err_clr) || udf_set;
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;
`endif

endmodule
